// File: rtl/uart_tx_feeder.sv
// Byte FIFO and launch sequencer feeding an 8-bit UART transmitter on the baud clock.
// Each queued byte is presented on o_tx_data with a one-cycle o_tx_start; a watchdog aborts a missing tx_done.
module uart_tx_feeder #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_wr_en,
    input  logic [7:0]        i_wr_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow,
    output logic              o_timeout_err,
    output logic              o_tx_start,
    output logic [7:0]        o_tx_data,
    input  logic              i_tx_busy,
    input  logic              i_tx_done
);

    localparam int WDOG_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [7:0]          r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_count;
    logic                r_full;
    logic                r_empty;
    logic                r_overflow;
    logic                r_timeout_err;
    logic                r_tx_start;
    logic [7:0]          r_tx_data;
    logic [WDOG_W-1:0]   r_wdog;

    logic                w_pop;
    logic                w_push;
    logic                w_overflow;
    logic                w_timeout;
    logic [ADDR_W:0]     w_count_next;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = S_IDLE;
        case (r_state)
            S_IDLE:      w_state_next = w_pop ? S_LAUNCH : S_IDLE;
            S_LAUNCH:    w_state_next = S_WAIT_DONE;
            S_WAIT_DONE: w_state_next = (i_tx_done || w_timeout) ? S_IDLE : S_WAIT_DONE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    // Launch only into a transmitter that is fully quiet; tx_done beats the watchdog.
    always_comb begin
        w_pop      = (r_state == S_IDLE) && i_en && !r_empty && !i_tx_busy && !i_tx_done;
        w_timeout  = (r_state == S_WAIT_DONE) && !i_tx_done && (r_wdog == WDOG_W'(TIMEOUT - 1));
        w_push     = i_wr_en && (!r_full || w_pop);
        w_overflow = i_wr_en && r_full && !w_pop;
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + (ADDR_W+1)'(1);
            2'b01:   w_count_next = r_count - (ADDR_W+1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    // NOTE: storage array has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_overflow    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= 8'h00;
            r_wdog        <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
                r_tx_data <= r_mem[r_rd_ptr];
            end
            r_count       <= w_count_next;
            r_full        <= (w_count_next == (ADDR_W+1)'(DEPTH));
            r_empty       <= (w_count_next == '0);
            r_overflow    <= w_overflow;
            r_timeout_err <= w_timeout;
            r_tx_start    <= w_pop;
            if (r_state == S_LAUNCH)         r_wdog <= '0;
            else if (r_state == S_WAIT_DONE) r_wdog <= r_wdog + WDOG_W'(1);
        end
    end

    assign o_full        = r_full;
    assign o_empty       = r_empty;
    assign o_count       = r_count;
    assign o_overflow    = r_overflow;
    assign o_timeout_err = r_timeout_err;
    assign o_tx_start    = r_tx_start;
    assign o_tx_data     = r_tx_data;

endmodule
